sha256_round_ctrl: RTL and testbench
====================================

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameters SHALL be none; the block is fixed at 64 rounds, 32-bit words and 512-bit blocks.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 blk_valid  input  1  blk_word is valid this cycle.
REQ-005 blk_ready  output  1  block accepts a word this cycle; transfer = blk_valid & blk_ready.
REQ-006 blk_word  input  32  message word, big-endian order, W0 first.
REQ-007 init  input  1  sampled with word 0 only: 1 = start a new message from IV, 0 = chain from current H.
REQ-008 busy  output  1  high in LOAD, ROUND, UPDATE and DONE.
REQ-009 digest  output  256  H0..H7 concatenated, H0 in bits [255:224]; driven directly from the H registers.
REQ-010 digest_valid  output  1  one-cycle pulse when digest holds the result of the last block.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, ROUND, UPDATE and DONE.
REQ-012 blk_ready SHALL be high in IDLE and LOAD and low in all other states.
REQ-013 IDLE: a transfer stores word 0, samples init, loads H from IV if init=1, loads a..h from the resulting H, sets word count to 1 and moves to LOAD.
REQ-014 LOAD: each transfer stores the next word and increments the count; no transfer means a stall with all state held; the transfer of word 15 moves the FSM to ROUND with t=0.
REQ-015 ROUND: one round per cycle, t = 0..63; t=63 moves to UPDATE.
- T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
- T2 = Σ0(a) + Maj(a,b,c)
- all sums mod 2^32
- h..a <= g, f, e, d+T1, c, b, a, T1+T2
REQ-016 W[t] for t<16 SHALL be the loaded word; for t>=16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] mod 2^32, computed in a 16-word sliding window (no 64-word store).
REQ-017 Rotate/shift functions:
- Σ0 = ROTR2^ROTR13^ROTR22
- Σ1 = ROTR6^ROTR11^ROTR25
- σ0 = ROTR7^ROTR18^SHR3
- σ1 = ROTR17^ROTR19^SHR10
REQ-018 UPDATE (1 cycle): Hi <= Hi + working variable i, mod 2^32 each; then DONE.
REQ-019 DONE (1 cycle): digest_valid=1; then IDLE.
REQ-020 Latency: if word 15 transfers in cycle N, rounds occupy N+1..N+64, UPDATE is N+65 and the digest_valid pulse is N+66.
REQ-021 digest SHALL stay stable from DONE until the next UPDATE.
REQ-022 blk_valid during ROUND, UPDATE or DONE SHALL be ignored, with no word consumed.
REQ-023 init on words 1..15 SHALL be ignored.
REQ-024 A chained block (init=0) with no prior message after reset SHALL chain from IV.

Reset
REQ-025 rst_n low SHALL asynchronously force:
- FSM = IDLE; word count = 0; t = 0
- H = IV; a..h = 0; W window = 0
- digest_valid = 0, busy = 0, blk_ready = 0 while asserted
REQ-026 After rst_n deasserts, blk_ready SHALL be 1 in the first cycle.
REQ-027 Reset mid-LOAD or mid-ROUND SHALL discard the block with no digest_valid pulse.

Structure
REQ-028 A package sha256_pkg SHALL hold:
- K[0:63] constants and IV[0:7]
- the FSM state enum
- Σ0/Σ1/σ0/σ1/Ch/Maj functions
REQ-029 One sub-module, sha256_msg_sched, SHALL implement the 16-word window and the W[t] output, with controls load and shift.
REQ-030 Round datapath, H registers and FSM SHALL reside in sha256_round_ctrl.

Verification
REQ-031 "abc" (init=1; words 61626380, 0 x14, 00000018) -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-032 Empty message (init=1; word 0 = 80000000, rest 0) -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-033 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block 1 init=1, block 2 init=0) -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; digest_valid pulses once per block.
REQ-034 "abc" with random blk_valid gaps and blk_valid held high during ROUND -> same digest as REQ-031; blk_ready=0 throughout ROUND; digest_valid exactly 66 cycles after word-15 transfer.
REQ-035 rst_n pulsed low at round t=30 -> no digest_valid, busy=0, digest=IV; a following "abc" run yields the REQ-031 digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 compression block:
//   - K[0:63]  round constants
//   - IV[0:7]  initial hash value H0..H7
//   - state_t  controller FSM states
//   - big_sigma0/1, small_sigma0/1, ch, maj  word functions
// ---------------------------------------------------------------------------
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// 16-word sliding window message schedule. Slot 0 always holds W[t].
// Ports:
//   clk, rst_n  clock / async active-low reset (window cleared)
//   load        shift load_word into the top of the window (block loading)
//   shift       shift the expanded word W[t+16] into the top (one per round)
//   load_word   incoming message word
//   w_t         current schedule word W[t]
// ---------------------------------------------------------------------------
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] load_word,
    output logic [31:0] w_t
);

    logic [31:0] win [0:15];
    logic [31:0] next_w;

    // With slot 0 = W[t], slots 1, 9 and 14 hold W[t+1], W[t+9] and
    // W[t+14], which is exactly what W[t+16] needs.
    always_comb begin
        next_w = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
    end

    assign w_t = win[0];

    // Both loading and expanding move the window down by one slot; only the
    // word entering at the top differs. Sixteen loads fully replace any
    // stale content, so W0 ends up in slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'h0;
            end
        end else if (load || shift) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= load ? load_word : next_w;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl
// SHA-256 compression of one 512-bit block per message chunk: accepts 16
// words over a valid/ready handshake, runs 64 rounds (one per cycle), adds
// the working variables into H and pulses digest_valid.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   blk_valid      blk_word valid this cycle
//   blk_ready      block accepts a word (IDLE and LOAD only)
//   blk_word       message word, W0 first
//   init           with word 0: 1 = start from IV, 0 = chain from current H
//   busy           high whenever not IDLE
//   digest         {H0..H7}, H0 in the top bits
//   digest_valid   one-cycle pulse when digest holds the block result
// ---------------------------------------------------------------------------
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [31:0]  blk_word,
    input  logic         init,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  word_count;
    logic [5:0]  round_idx;
    logic [31:0] h_reg [0:7];
    logic [31:0] wv    [0:7];
    logic [31:0] w_t;
    logic [31:0] t1;
    logic [31:0] t2;
    logic        transfer;
    logic        sched_shift;

    assign transfer = blk_valid & blk_ready;

    sha256_msg_sched u_msg_sched (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (transfer),
        .shift     (sched_shift),
        .load_word (blk_word),
        .w_t       (w_t)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs. blk_ready is also gated by rst_n so
    // the block refuses words while reset is held.
    always_comb begin
        state_next   = state;
        blk_ready    = 1'b0;
        busy         = 1'b1;
        digest_valid = 1'b0;
        sched_shift  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                blk_ready = rst_n;
                if (transfer) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                blk_ready = rst_n;
                if (transfer && word_count == 4'd15) begin
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                sched_shift = 1'b1;
                if (round_idx == 6'd63) begin
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Round function on the current working variables (index 0 = a).
    always_comb begin
        t1 = wv[7] + big_sigma1(wv[4]) + ch(wv[4], wv[5], wv[6]) + K[round_idx] + w_t;
        t2 = big_sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);
    end

    // Datapath: word counting, round counter, working variables and H.
    // Word 0 decides between IV and chaining; the working variables are
    // seeded from the H that word 0 selects. round_idx wraps back to 0
    // after round 63, so it is ready for the next block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= 4'd0;
            round_idx  <= 6'd0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV[i];
                wv[i]    <= 32'h0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        word_count <= 4'd1;
                        for (int i = 0; i < 8; i++) begin
                            if (init) begin
                                h_reg[i] <= IV[i];
                                wv[i]    <= IV[i];
                            end else begin
                                wv[i]    <= h_reg[i];
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (transfer) begin
                        if (word_count == 4'd15) begin
                            word_count <= 4'd0;
                            round_idx  <= 6'd0;
                        end else begin
                            word_count <= word_count + 4'd1;
                        end
                    end
                end
                ST_ROUND: begin
                    wv[7]     <= wv[6];
                    wv[6]     <= wv[5];
                    wv[5]     <= wv[4];
                    wv[4]     <= wv[3] + t1;
                    wv[3]     <= wv[2];
                    wv[2]     <= wv[1];
                    wv[1]     <= wv[0];
                    wv[0]     <= t1 + t2;
                    round_idx <= round_idx + 6'd1;
                end
                ST_UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        h_reg[i] <= h_reg[i] + wv[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign digest = {h_reg[0], h_reg[1], h_reg[2], h_reg[3],
                     h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_round_ctrl
// Directed bench for sha256_round_ctrl using known SHA-256 digests.
// ---------------------------------------------------------------------------
module tb_sha256_round_ctrl;

    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [31:0]  blk_word;
    logic         init;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;

    int checks;
    int errors;
    int pulse_count;
    logic [31:0] msg_words [0:15];

    localparam logic [255:0] DIG_IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    sha256_round_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_word     (blk_word),
        .init         (init),
        .busy         (busy),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every digest_valid pulse so block counts can be checked.
    always @(negedge clk) begin
        if (digest_valid) begin
            pulse_count <= pulse_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Sends the 16 words in msg_words; word 0 carries init_w0, later words
    // carry the opposite init value, which the block must ignore. Returns
    // just after the clock edge that transfers word 15.
    task automatic applyStimulus(input logic init_w0, input int gap_max);
        for (int i = 0; i < 16; i++) begin
            int gaps;
            int bound;
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gaps) begin
                @(negedge clk);
                blk_valid = 1'b0;
            end
            @(negedge clk);
            blk_valid = 1'b1;
            blk_word  = msg_words[i];
            init      = (i == 0) ? init_w0 : ~init_w0;
            bound     = 0;
            while (!blk_ready && bound < 100) begin
                @(negedge clk);
                bound++;
            end
            if (!blk_ready) begin
                checkOutput("ready_timeout", 256'(blk_ready), 256'(1));
            end
            @(posedge clk);
        end
    endtask

    // Waits for digest_valid (bounded), optionally holding blk_valid high
    // through the rounds, then checks latency, digest and stability.
    task automatic waitDigest(input string tag, input logic hold_valid,
                              input logic check_dig, input logic [255:0] expected);
        int   k;
        logic ready_seen;
        #1;
        blk_valid  = hold_valid;
        blk_word   = 32'hdeadbeef;
        k          = 0;
        ready_seen = 1'b0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (k <= 65 && blk_ready) ready_seen = 1'b1;
            if (digest_valid) break;
        end
        blk_valid = 1'b0;
        checkOutput({tag, "_latency"}, 256'(k), 256'(66));
        checkOutput({tag, "_ready_in_round"}, 256'(ready_seen), 256'(0));
        if (check_dig) checkOutput({tag, "_digest"}, digest, expected);
        @(negedge clk);
        checkOutput({tag, "_pulse_width"}, 256'(digest_valid), 256'(0));
        checkOutput({tag, "_busy_after"}, 256'(busy), 256'(0));
        if (check_dig) checkOutput({tag, "_digest_hold"}, digest, expected);
    endtask

    task automatic setAbc();
        msg_words     = '{default: 32'h0};
        msg_words[0]  = 32'h61626380;
        msg_words[15] = 32'h00000018;
    endtask

    initial begin
        int pulses_before;
        checks      = 0;
        errors      = 0;
        pulse_count = 0;
        rst_n       = 1'b0;
        blk_valid   = 1'b0;
        blk_word    = 32'h0;
        init        = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 256'(blk_ready), 256'(0));
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_dvalid", 256'(digest_valid), 256'(0));
        checkOutput("rst_digest", digest, DIG_IV);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 256'(blk_ready), 256'(1));

        // Chaining right after reset must start from IV.
        setAbc();
        applyStimulus(1'b0, 0);
        waitDigest("abc_chain_iv", 1'b0, 1'b1, DIG_ABC);

        // Empty message.
        msg_words    = '{default: 32'h0};
        msg_words[0] = 32'h80000000;
        applyStimulus(1'b1, 0);
        waitDigest("empty", 1'b0, 1'b1, DIG_EMPTY);

        // Two-block message, second block chained.
        pulses_before = pulse_count;
        msg_words = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        applyStimulus(1'b1, 0);
        waitDigest("two_blk1", 1'b0, 1'b0, '0);
        msg_words     = '{default: 32'h0};
        msg_words[15] = 32'h000001c0;
        applyStimulus(1'b0, 0);
        waitDigest("two_blk2", 1'b0, 1'b1, DIG_TWO);
        @(posedge clk);
        checkOutput("two_pulses", 256'(pulse_count - pulses_before), 256'(2));

        // "abc" with random gaps and blk_valid held through the rounds.
        setAbc();
        applyStimulus(1'b1, 3);
        waitDigest("abc_gaps", 1'b1, 1'b1, DIG_ABC);

        // Reset in round t=30 must abort the block.
        setAbc();
        applyStimulus(1'b1, 0);
        repeat (31) @(negedge clk);
        checkOutput("mid_busy_before", 256'(busy), 256'(1));
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 256'(busy), 256'(0));
        checkOutput("mid_rst_ready", 256'(blk_ready), 256'(0));
        checkOutput("mid_rst_digest", digest, DIG_IV);
        pulses_before = pulse_count;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        @(posedge clk);
        checkOutput("mid_rst_no_pulse", 256'(pulse_count - pulses_before), 256'(0));
        checkOutput("mid_rst_idle", 256'(busy), 256'(0));
        checkOutput("mid_rst_digest_after", digest, DIG_IV);

        setAbc();
        applyStimulus(1'b1, 0);
        waitDigest("abc_after_rst", 1'b0, 1'b1, DIG_ABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
